// File: rtl/can_stuff.sv
// can_stuff: CAN transmit-side bit stuffer and serializer. Shifts a parallel
// unstuffed frame out index-0-first, one bit per CLKS_PER_BIT clocks, and inserts
// a complementary stuff bit after every 5 equal bits in the leading i_Stuff_Len bits.
// Ports: i_Clock/i_Reset_n (sync, active-low); i_Tx_DV start strobe (IDLE only);
//   i_Frame/i_Stuff_Len/i_Total_Len frame and lengths, latched at the strobe;
//   o_Tx_Serial bus bit (1 = recessive); o_Tx_Active while a bit period runs;
//   o_Stuff_Bit during an inserted bit; o_Stuff_Count inserted bits (saturating);
//   o_Tx_Done one-cycle pulse at normal completion.
// Optional macro CAN_STUFF_BIT_MONITOR_EN adds i_Rx_Serial / o_Bit_Error: a
//   mid-bit readback mismatch aborts the frame to IDLE without o_Tx_Done.
module can_stuff #(
  parameter int CLKS_PER_BIT = 10,
  parameter int MAX_BITS     = 128
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Tx_DV,
  input  logic [0:MAX_BITS-1] i_Frame,
  input  logic [7:0]          i_Stuff_Len,
  input  logic [7:0]          i_Total_Len,
`ifdef CAN_STUFF_BIT_MONITOR_EN
  input  logic                i_Rx_Serial,
  output logic                o_Bit_Error,
`endif
  output logic                o_Tx_Serial,
  output logic                o_Tx_Active,
  output logic                o_Stuff_Bit,
  output logic [7:0]          o_Stuff_Count,
  output logic                o_Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_MID  = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {IDLE, DATA, STUFF, CLEANUP} state_t;

  state_t              state, state_nxt;
  logic [0:MAX_BITS-1] frame_q;     // remaining bits; index 0 is the current data bit
  logic [7:0]          stuff_len;
  logic [7:0]          total_len;
  logic [7:0]          bit_idx;     // index of the current (or just-finished) data bit
  logic [7:0]          stuff_cnt;
  logic [CW-1:0]       clk_cnt;
  logic                last_val;    // value of the last transmitted bit
  logic [2:0]          run_cnt;     // length of the run ending at last_val
  logic                done_q;

  logic                active, bit_end, in_region, cur_bit, need_stuff, more_bits;
  logic [2:0]          run_nxt;
  logic [7:0]          eff_stuff;
  logic                bit_err;

  assign active    = (state == DATA) || (state == STUFF);
  assign bit_end   = (clk_cnt == CLK_LAST);
  assign cur_bit   = frame_q[0];
  assign in_region = (bit_idx < stuff_len);
  assign more_bits = ((bit_idx + 8'd1) < total_len);
  assign eff_stuff = (i_Stuff_Len < i_Total_Len) ? i_Stuff_Len : i_Total_Len;

  // Run including the data bit now ending. Outside the stuffed region the run
  // is pinned at 1 so nothing can trigger a stuff bit there. run_cnt starts
  // at 0, so the SOF always begins a fresh run of 1.
  assign run_nxt    = (in_region && (cur_bit == last_val)) ? run_cnt + 3'd1 : 3'd1;
  assign need_stuff = in_region && (run_nxt == 3'd5);

`ifdef CAN_STUFF_BIT_MONITOR_EN
  assign bit_err = active && (clk_cnt == CLK_MID) && (i_Rx_Serial != o_Tx_Serial);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) o_Bit_Error <= 1'b0;
    else            o_Bit_Error <= bit_err;
  end
`else
  assign bit_err = 1'b0;
`endif

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_Tx_DV) state_nxt = (i_Total_Len == 8'd0) ? CLEANUP : DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (need_stuff)     state_nxt = STUFF;
          else if (more_bits) state_nxt = DATA;
          else                state_nxt = CLEANUP;
        end
      end
      STUFF: begin
        if (bit_end) state_nxt = more_bits ? DATA : CLEANUP;
      end
      CLEANUP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bit_err) state_nxt = IDLE;
  end

  // Datapath: frame shifter, bit timing, run tracking and stuff counter
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      frame_q   <= '1;
      stuff_len <= '0;
      total_len <= '0;
      bit_idx   <= '0;
      stuff_cnt <= '0;
      clk_cnt   <= '0;
      last_val  <= 1'b1;
      run_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= (state == CLEANUP);
      clk_cnt <= (active && !bit_end && !bit_err) ? clk_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (i_Tx_DV) begin
            frame_q   <= i_Frame;
            stuff_len <= eff_stuff;
            total_len <= i_Total_Len;
            stuff_cnt <= '0;
            bit_idx   <= '0;
            run_cnt   <= '0;
            last_val  <= 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            // Consume the finished bit; refill with recessive ones.
            frame_q <= (frame_q << 1) | MAX_BITS'(1);
            if (need_stuff) begin
              // The stuff bit itself starts a new run of the opposite value.
              last_val  <= ~cur_bit;
              run_cnt   <= 3'd1;
              stuff_cnt <= (stuff_cnt == 8'hFF) ? stuff_cnt : stuff_cnt + 8'd1;
            end else begin
              last_val <= cur_bit;
              run_cnt  <= run_nxt;
              if (more_bits) bit_idx <= bit_idx + 8'd1;
            end
          end
        end
        STUFF: begin
          if (bit_end && more_bits) bit_idx <= bit_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // During STUFF last_val already holds the complemented stuff value.
  assign o_Tx_Serial   = (state == DATA) ? cur_bit : (state == STUFF) ? last_val : 1'b1;
  assign o_Tx_Active   = active;
  assign o_Stuff_Bit   = (state == STUFF);
  assign o_Stuff_Count = stuff_cnt;
  assign o_Tx_Done     = done_q;

endmodule

// File: tb/tb_can_stuff.sv
// Directed bench for can_stuff: captures each bit at mid-period, records the
// o_Tx_Done cycle relative to the strobe edge and compares with hand-derived
// bit patterns, stuff masks and counts.
module tb_can_stuff;
  localparam int CPB = 10;
  localparam int MB  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_dv;
  logic [0:MB-1] frame;
  logic [7:0]    stuff_len, total_len;
  logic          tx_serial, tx_active, stuff_bit, tx_done;
  logic [7:0]    stuff_count;

  int checks = 0;
  int errors = 0;

`ifdef CAN_STUFF_BIT_MONITOR_EN
  logic rx_serial, bit_error;
  logic force_zero = 1'b0;
  assign rx_serial = force_zero ? 1'b0 : tx_serial;
`endif

  can_stuff #(.CLKS_PER_BIT(CPB), .MAX_BITS(MB)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Tx_DV      (tx_dv),
    .i_Frame      (frame),
    .i_Stuff_Len  (stuff_len),
    .i_Total_Len  (total_len),
`ifdef CAN_STUFF_BIT_MONITOR_EN
    .i_Rx_Serial  (rx_serial),
    .o_Bit_Error  (bit_error),
`endif
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Active  (tx_active),
    .o_Stuff_Bit  (stuff_bit),
    .o_Stuff_Count(stuff_count),
    .o_Tx_Done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe a frame and follow it until o_Tx_Done (or a cycle budget expires).
  // k counts cycles after the strobe edge; outputs are sampled 1 time unit
  // after each edge. ser/stf bit j = serial / stuff flag of bit period j.
  // At k == glitch_k a second strobe with different inputs is presented.
  task automatic send(input logic [0:MB-1] f, input logic [7:0] sl, input logic [7:0] tl,
                      input int glitch_k,
                      output logic [31:0] ser, output logic [31:0] stf, output int nb,
                      output int done_k, output logic act_seen, output logic idle_low);
    frame = f; stuff_len = sl; total_len = tl; tx_dv = 1'b1;
    @(posedge clk); #1;
    tx_dv = 1'b0;
    ser = '0; stf = '0; nb = 0; done_k = -1; act_seen = 1'b0; idle_low = 1'b0;
    for (int k = 0; k < 400 && done_k < 0; k++) begin
      if (tx_active) act_seen = 1'b1;
      if (!tx_active && tx_serial == 1'b0) idle_low = 1'b1;
      if (tx_active && (k % CPB) == CPB / 2 && nb < 32) begin
        ser[nb] = tx_serial;
        stf[nb] = stuff_bit;
        nb++;
      end
      if (tx_done) done_k = k;
      if (k == glitch_k) begin
        tx_dv = 1'b1; frame = '0; stuff_len = 8'd3; total_len = 8'd3;
      end else begin
        tx_dv = 1'b0;
      end
      @(posedge clk); #1;
    end
    tx_dv = 1'b0;
  endtask

  logic [31:0] ser, stf;
  int          nb, done_k;
  logic        act_seen, idle_low, done_seen;

  localparam logic [0:MB-1] EX1  = 16'b0000011111_111111;
  localparam logic [0:MB-1] ONES = 16'hFFFF;

  initial begin
    rst_n = 1'b0; tx_dv = 1'b0; frame = '1; stuff_len = '0; total_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_serial", {31'd0, tx_serial}, 32'd1);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    check("rst_count",  {24'd0, stuff_count}, 32'd0);
    check("rst_done",   {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0000011111: 00000 1* 1111 0* 1
    send(EX1, 8'd10, 8'd10, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("ex1_serial", ser, 32'hBE0);
    check("ex1_stuff",  stf, 32'h420);
    check("ex1_nbits",  nb, 32'd12);
    check("ex1_count",  {24'd0, stuff_count}, 32'd2);
    check("ex1_done_k", done_k, 32'd121);
    check("ex1_done_1cyc", {31'd0, tx_done}, 32'd0);

    // All ones: 11111 0* 11111 0*, trailing stuff bit included
    send(ONES, 8'd10, 8'd10, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("ones_serial", ser, 32'h7DF);
    check("ones_stuff",  stf, 32'h820);
    check("ones_count",  {24'd0, stuff_count}, 32'd2);
    check("ones_done_k", done_k, 32'd121);

    // No stuffed region: ten raw ones
    send(ONES, 8'd0, 8'd10, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("sl0_serial", ser, 32'h3FF);
    check("sl0_stuff",  stf, 32'h0);
    check("sl0_count",  {24'd0, stuff_count}, 32'd0);
    check("sl0_done_k", done_k, 32'd101);

    // Stuff length beyond total is clamped to total
    send(ONES, 8'd20, 8'd10, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("sl20_serial", ser, 32'h7DF);
    check("sl20_stuff",  stf, 32'h820);
    check("sl20_count",  {24'd0, stuff_count}, 32'd2);

    // Zero-length frame: nothing sent; done in the cycle after the strobe edge,
    // i.e. two cycles after the cycle in which the strobe is presented
    send(ONES, 8'd5, 8'd0, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("zero_active", {31'd0, act_seen}, 32'd0);
    check("zero_serial", {31'd0, idle_low}, 32'd0);
    check("zero_done_k", done_k, 32'd1);
    check("zero_count",  {24'd0, stuff_count}, 32'd0);

    // Second strobe with changed inputs mid-frame is ignored
    send(EX1, 8'd10, 8'd10, 30, ser, stf, nb, done_k, act_seen, idle_low);
    check("glitch_serial", ser, 32'hBE0);
    check("glitch_done_k", done_k, 32'd121);

    // Reset pulse during bit period 3 of EX1 (a dominant bit)
    frame = EX1; stuff_len = 8'd10; total_len = 8'd10; tx_dv = 1'b1;
    @(posedge clk); #1;
    tx_dv = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("pre_rst_serial", {31'd0, tx_serial}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_serial", {31'd0, tx_serial}, 32'd1);
    check("mid_rst_active", {31'd0, tx_active}, 32'd0);
    check("mid_rst_count",  {24'd0, stuff_count}, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (tx_done || tx_active) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_rst_quiet", {31'd0, done_seen}, 32'd0);

    send(ONES, 8'd10, 8'd10, -1, ser, stf, nb, done_k, act_seen, idle_low);
    check("post_rst_serial", ser, 32'h7DF);
    check("post_rst_done_k", done_k, 32'd121);
    repeat (3) @(posedge clk);
    #1;
    check("count_hold", {24'd0, stuff_count}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("count_rst", {24'd0, stuff_count}, 32'd0);

`ifdef CAN_STUFF_BIT_MONITOR_EN
    // Readback forced dominant during bit period 2 of an all-ones frame;
    // the compare happens at k = 25, the abort is visible at k = 26.
    frame = ONES; stuff_len = 8'd10; total_len = 8'd10; tx_dv = 1'b1;
    @(posedge clk); #1;
    tx_dv = 1'b0;
    check("mon_err_idle", {31'd0, bit_error}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    force_zero = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mon_err_pulse", {31'd0, bit_error}, 32'd1);
    check("mon_serial",    {31'd0, tx_serial}, 32'd1);
    check("mon_active",    {31'd0, tx_active}, 32'd0);
    @(posedge clk); #1;
    check("mon_err_1cyc",  {31'd0, bit_error}, 32'd0);
    force_zero = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (tx_done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mon_no_done", {31'd0, done_seen}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_stuff.md
Name: can_stuff

Overview:
- Transmit-side bit stuffer and serializer for the CAN datapath; the counterpart of the receive-side destuffer.
- Takes a complete unstuffed frame as a parallel vector and shifts it out first-index-first on the bus line, one bit per CLKS_PER_BIT clocks.
- Inserts a complementary stuff bit after every 5 equal consecutive bits inside the stuffed region (SOF through CRC); the remaining bits (CRC delimiter, ACK, EOF) go out raw.
- Sits between the frame builder and the bus driver.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per nominal bit; legal range 2 and up.
- MAX_BITS, 128, width of the frame vector; legal range 1 to 255.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Tx_DV  in  1  start strobe; sampled only in IDLE.
- i_Frame  in  [0:MAX_BITS-1]  unstuffed frame; index 0 = SOF, transmitted first.
- i_Stuff_Len  in  8  number of leading bits subject to stuffing.
- i_Total_Len  in  8  total unstuffed bits to send.
- o_Tx_Serial  out  1  bus bit; 1 = recessive.
- o_Tx_Active  out  1  high while any bit period is in progress.
- o_Stuff_Bit  out  1  high for the whole period of an inserted stuff bit.
- o_Stuff_Count  out  8  stuff bits inserted in the current/last frame; saturates at 255.
- o_Tx_Done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (i_Reset_n=0 at a clock edge) applies on the next cycle, including mid-frame:
  - o_Tx_Serial=1, o_Tx_Active=0, o_Stuff_Bit=0, o_Stuff_Count=0, o_Tx_Done=0.
  - State IDLE; all counters cleared.
- States: IDLE, DATA, STUFF, CLEANUP.
- IDLE:
  - o_Tx_Serial=1.
  - On i_Tx_DV=1: latch i_Frame; latch effective stuff length = min(i_Stuff_Len, i_Total_Len); latch i_Total_Len; clear o_Stuff_Count.
  - If latched total = 0: go to CLEANUP, so o_Tx_Done pulses two cycles after the strobe and nothing is sent.
  - Otherwise go to DATA with bit index 0. The first bit appears on o_Tx_Serial the cycle after the strobe edge.
- Bit timing: clock counter runs 0..CLKS_PER_BIT-1. Each bit (data or stuff) holds o_Tx_Serial for exactly CLKS_PER_BIT cycles. Bits are back-to-back with no gaps.
- Run tracking:
  - Keep the last transmitted value and a run count (1..5).
  - Every transmitted bit updates the run, stuff bits included: a stuff bit starts a new run of 1 with the complemented value.
- DATA, at end of a bit period:
  - If the bit index is below the stuff length and the run has reached 5: go to STUFF, driving ~last value. This includes after the final stuffed-region bit, so a stuff bit can precede the CRC delimiter.
  - Else if more bits remain: increment the index and stay in DATA.
  - Else: go to CLEANUP.
- Run reset: on the first bit at or after the stuff length, the run count resets and no further stuffing occurs.
- STUFF:
  - o_Stuff_Bit=1 for the whole period.
  - o_Stuff_Count increments once, at entry.
  - At the end of the period: return to DATA with the next index, or go to CLEANUP if none remain.
- CLEANUP:
  - One cycle: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=1.
  - Then go to IDLE.
  - o_Stuff_Count holds its value until the next start.
- i_Tx_DV outside IDLE is ignored. Input changes after the latch have no effect.
- Total frame duration = (i_Total_Len + stuff count) × CLKS_PER_BIT cycles.

Optional Feature:
- Macro: CAN_STUFF_BIT_MONITOR_EN.
- When defined:
  - Adds input i_Rx_Serial (1 bit) and output o_Bit_Error (1 bit, reset 0).
  - At clock count CLKS_PER_BIT/2 of every bit period, i_Rx_Serial is compared with o_Tx_Serial.
  - On a mismatch:
    - o_Bit_Error pulses for one cycle.
    - o_Tx_Serial returns to 1 on the next cycle.
    - The FSM goes directly to IDLE with no o_Tx_Done pulse.
    - o_Stuff_Count is held.
- When undefined: neither port exists and there is no comparison logic.

Test Plan:
- Frame 0000011111, Stuff_Len=10, Total_Len=10 -> serial 0,0,0,0,0,1*,1,1,1,1,0*,1 (* = o_Stuff_Bit high); o_Stuff_Count=2; o_Tx_Done exactly 121 cycles after the strobe edge (CLKS_PER_BIT=10).
- Frame 1111111111, Stuff_Len=10, Total_Len=10 -> 11111 0* 11111 0* (trailing stuff bit inserted); count=2; 12 bit periods.
- Same frame, Stuff_Len=0 -> 10 raw bits, no o_Stuff_Bit, count=0. Stuff_Len=20 with Total_Len=10 -> identical to Stuff_Len=10.
- Strobe with Total_Len=0 -> o_Tx_Serial stays 1, o_Tx_Active never rises, o_Tx_Done pulses 2 cycles after the strobe; a second i_Tx_DV during an active frame -> ignored, no output change.
- i_Reset_n low for 1 cycle during bit 3 of a frame -> the next cycle shows o_Tx_Serial=1, Active=0, count=0; a new strobe then sends a correct frame.
- With CAN_STUFF_BIT_MONITOR_EN: i_Rx_Serial forced 0 during a transmitted 1 at bit 2 -> o_Bit_Error pulses at mid-bit, serial=1 the next cycle, no o_Tx_Done.
